dmem_arb: RTL

DMEM_ARB -- requirements
Module: dmem_arb

---
 rtl/dmem_arb.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arb.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb
// Description : Two-master data-memory arbiter. The load and store channels
//               are independent single-outstanding round-robin arbiters with
//               a hold lock, and the response paths are combinational.
// Revision    : 1.0 - initial release
// ============================================================================

module dmem_arb_chan (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_m_valid,
    input  logic       i_d_ready,
    input  logic       i_d_resp_valid,
    input  logic [1:0] i_m_resp_ready,
    output logic [1:0] o_m_ready,
    output logic       o_d_valid,
    output logic       o_sel,
    output logic [1:0] o_m_resp_valid,
    output logic       o_d_resp_ready,
    output logic       o_unexp
);
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RESP = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       r_rr_ptr;
    logic       w_rr_nxt;
    logic       r_lock_vld;
    logic       w_lock_vld_nxt;
    logic       r_lock_m;
    logic       w_lock_m_nxt;
    logic       r_owner;
    logic       w_owner_nxt;
    logic       w_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_rr_ptr   <= 1'b0;
            r_lock_vld <= 1'b0;
            r_lock_m   <= 1'b0;
            r_owner    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_lock_vld <= w_lock_vld_nxt;
            r_lock_m   <= w_lock_m_nxt;
            r_owner    <= w_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr_ptr;
        w_lock_vld_nxt = r_lock_vld;
        w_lock_m_nxt   = r_lock_m;
        w_owner_nxt    = r_owner;
        o_m_ready      = 2'b00;
        o_d_valid      = 1'b0;
        o_m_resp_valid = 2'b00;
        o_d_resp_ready = 1'b0;
        o_unexp        = 1'b0;

        // A held lock keeps its master even if that master drops valid
        if (r_lock_vld)
            o_sel = r_lock_m;
        else if (i_m_valid[0] ^ i_m_valid[1])
            o_sel = i_m_valid[1];
        else
            o_sel = r_rr_ptr;
        w_any = r_lock_vld ? i_m_valid[r_lock_m] : (|i_m_valid);

        case (r_state)
            c_IDLE: begin
                o_d_valid        = w_any;
                o_m_ready[o_sel] = i_d_ready;
                o_d_resp_ready   = 1'b1;
                o_unexp          = i_d_resp_valid;
                if (w_any && i_d_ready) begin
                    w_state_nxt    = c_RESP;
                    w_owner_nxt    = o_sel;
                    w_rr_nxt       = ~o_sel;
                    w_lock_vld_nxt = 1'b0;
                end else if (w_any) begin
                    w_lock_vld_nxt = 1'b1;
                    w_lock_m_nxt   = o_sel;
                end
            end
            c_RESP: begin
                o_m_resp_valid[r_owner] = i_d_resp_valid;
                o_d_resp_ready          = i_m_resp_ready[r_owner];
                if (i_d_resp_valid && i_m_resp_ready[r_owner])
                    w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase

        if (rst) begin
            o_m_ready      = 2'b00;
            o_d_valid      = 1'b0;
            o_m_resp_valid = 2'b00;
            o_d_resp_ready = 1'b0;
            o_unexp        = 1'b0;
        end
    end
endmodule

module dmem_arb #(
    parameter int LDTAG_W = 4,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m0_ld_valid,
    output logic               m0_ld_ready,
    input  logic [ADDR_W-1:0]  m0_ld_addr,
    input  logic [LDTAG_W-1:0] m0_ld_tag,
    output logic               m0_ld_resp_valid,
    input  logic               m0_ld_resp_ready,
    output logic [63:0]        m0_ld_resp_data,
    output logic [LDTAG_W-1:0] m0_ld_resp_tag,
    output logic               m0_ld_resp_err,
    input  logic               m0_st_valid,
    output logic               m0_st_ready,
    input  logic [ADDR_W-1:0]  m0_st_addr,
    input  logic [63:0]        m0_st_wdata,
    input  logic [7:0]         m0_st_wstrb,
    output logic               m0_st_resp_valid,
    input  logic               m0_st_resp_ready,
    input  logic               m1_ld_valid,
    output logic               m1_ld_ready,
    input  logic [ADDR_W-1:0]  m1_ld_addr,
    input  logic [LDTAG_W-1:0] m1_ld_tag,
    output logic               m1_ld_resp_valid,
    input  logic               m1_ld_resp_ready,
    output logic [63:0]        m1_ld_resp_data,
    output logic [LDTAG_W-1:0] m1_ld_resp_tag,
    output logic               m1_ld_resp_err,
    input  logic               m1_st_valid,
    output logic               m1_st_ready,
    input  logic [ADDR_W-1:0]  m1_st_addr,
    input  logic [63:0]        m1_st_wdata,
    input  logic [7:0]         m1_st_wstrb,
    output logic               m1_st_resp_valid,
    input  logic               m1_st_resp_ready,
    output logic               d_ld_valid,
    input  logic               d_ld_ready,
    output logic [ADDR_W-1:0]  d_ld_addr,
    output logic [LDTAG_W-1:0] d_ld_tag,
    input  logic               d_ld_resp_valid,
    output logic               d_ld_resp_ready,
    input  logic [63:0]        d_ld_resp_data,
    input  logic [LDTAG_W-1:0] d_ld_resp_tag,
    input  logic               d_ld_resp_err,
    output logic               d_st_valid,
    input  logic               d_st_ready,
    output logic [ADDR_W-1:0]  d_st_addr,
    output logic [63:0]        d_st_wdata,
    output logic [7:0]         d_st_wstrb,
    input  logic               d_st_resp_valid,
    output logic               d_st_resp_ready,
    output logic               err_unexp
);
    logic w_ld_sel;
    logic w_st_sel;
    logic w_ld_unexp;
    logic w_st_unexp;
    logic r_err_unexp;

    dmem_arb_chan u_ld (
        .clk            (clk),
        .rst            (rst),
        .i_m_valid      ({m1_ld_valid, m0_ld_valid}),
        .i_d_ready      (d_ld_ready),
        .i_d_resp_valid (d_ld_resp_valid),
        .i_m_resp_ready ({m1_ld_resp_ready, m0_ld_resp_ready}),
        .o_m_ready      ({m1_ld_ready, m0_ld_ready}),
        .o_d_valid      (d_ld_valid),
        .o_sel          (w_ld_sel),
        .o_m_resp_valid ({m1_ld_resp_valid, m0_ld_resp_valid}),
        .o_d_resp_ready (d_ld_resp_ready),
        .o_unexp        (w_ld_unexp)
    );

    dmem_arb_chan u_st (
        .clk            (clk),
        .rst            (rst),
        .i_m_valid      ({m1_st_valid, m0_st_valid}),
        .i_d_ready      (d_st_ready),
        .i_d_resp_valid (d_st_resp_valid),
        .i_m_resp_ready ({m1_st_resp_ready, m0_st_resp_ready}),
        .o_m_ready      ({m1_st_ready, m0_st_ready}),
        .o_d_valid      (d_st_valid),
        .o_sel          (w_st_sel),
        .o_m_resp_valid ({m1_st_resp_valid, m0_st_resp_valid}),
        .o_d_resp_ready (d_st_resp_ready),
        .o_unexp        (w_st_unexp)
    );

    assign d_ld_addr  = w_ld_sel ? m1_ld_addr  : m0_ld_addr;
    assign d_ld_tag   = w_ld_sel ? m1_ld_tag   : m0_ld_tag;
    assign d_st_addr  = w_st_sel ? m1_st_addr  : m0_st_addr;
    assign d_st_wdata = w_st_sel ? m1_st_wdata : m0_st_wdata;
    assign d_st_wstrb = w_st_sel ? m1_st_wstrb : m0_st_wstrb;

    // Response payload is broadcast; only the owner's resp_valid qualifies it
    assign m0_ld_resp_data = d_ld_resp_data;
    assign m0_ld_resp_tag  = d_ld_resp_tag;
    assign m0_ld_resp_err  = d_ld_resp_err;
    assign m1_ld_resp_data = d_ld_resp_data;
    assign m1_ld_resp_tag  = d_ld_resp_tag;
    assign m1_ld_resp_err  = d_ld_resp_err;

    always_ff @(posedge clk) begin
        if (rst)
            r_err_unexp <= 1'b0;
        else if (w_ld_unexp || w_st_unexp)
            r_err_unexp <= 1'b1;
    end

    assign err_unexp = r_err_unexp;
endmodule

`default_nettype wire
